// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_updown_counter
//  Brief    : Loadable up/down modulo counter (0..MAX) stepped by a
//             synchronised, edge-detected active-low pushbutton.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 9,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_n,
    input  logic             en,
    input  logic             up,
    input  logic             load_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    generate
        if (WIDTH < 1 || WIDTH > 16 || MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_params
            $error("mod_updown_counter: illegal WIDTH/MAX combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic             c_wrap = (SATURATE == 0);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             w_step_evt;

    // Falling edge of the synchronised key; the chain resets to "pressed"
    // so a key held through reset release never produces an event.
    assign w_step_evt = r_s3 & ~r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
            r_q  <= c_zero;
            r_tc <= 1'b0;
        end else begin
            r_s1 <= step_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_tc <= 1'b0;
            if (!load_n) begin
                r_q <= (d > c_max) ? c_max : d;
            end else if (w_step_evt && en) begin
                if (up) begin
                    if (r_q == c_max) begin
                        if (c_wrap) begin
                            r_q  <= c_zero;
                            r_tc <= 1'b1;
                        end
                    end else begin
                        r_q <= r_q + c_one;
                    end
                end else begin
                    if (r_q == c_zero) begin
                        if (c_wrap) begin
                            r_q  <= c_max;
                            r_tc <= 1'b1;
                        end
                    end else begin
                        r_q <= r_q - c_one;
                    end
                end
            end
        end
    end

    assign q      = r_q;
    assign tc     = r_tc;
    assign at_max = (r_q == c_max);
    assign at_min = (r_q == c_zero);

endmodule
`default_nettype wire
